pipeline_fetch_q: RTL and testbench

PIPELINE_FETCH_Q -- requirements
Module: pipeline_fetch_q

---
 rtl/pipeline_fetch_q.sv | 109 ++++++++++
 tb/tb_pipeline_fetch_q.sv | 127 ++++++++++++
 2 files changed

// File: rtl/pipeline_fetch_q.sv
// Instruction fetch front end: issues one-deep outstanding reads, queues
// returned {pc, inst} pairs for DECODE, and handles redirects and memread stalls.
module pipeline_fetch_q #(
   parameter int              XLEN          = 32,
   parameter int              FQ_DEPTH      = 4,
   parameter int              MEMREAD_STALL = 3,
   parameter logic [XLEN-1:0] RESET_PC      = '0
) (
   input  logic            clk,
   input  logic            rst_n,
   output logic            im_req,
   output logic [XLEN-1:0] im_addr,
   input  logic [31:0]     im_rdata,
   input  logic            im_valid,
   input  logic            br_late_enable,
   input  logic [XLEN-1:0] br_late_target,
   input  logic            br_early_enable,
   input  logic [XLEN-1:0] br_early_target,
   input  logic            memread_enable,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] pc_out,
   output logic [31:0]     inst_out,
   output logic            br_late_done_d1
);

   localparam int AW = $clog2(FQ_DEPTH);
   localparam int PW = AW + 1;
   localparam int SW = $clog2(MEMREAD_STALL) + 1;

   logic [XLEN-1:0] pc_f, pend_pc;
   logic [XLEN-1:0] q_pc   [FQ_DEPTH];
   logic [31:0]     q_inst [FQ_DEPTH];
   logic [PW-1:0]   wptr, rptr, count;
   logic            pending, pend_epoch, epoch, first_cycle, late_d1;
   logic [SW-1:0]   stall_cnt;
   logic            stall, redirect, empty, full, fetch_room, push, pop;
   logic [XLEN-1:0] br_target;

   assign count    = wptr - rptr;
   assign empty    = (wptr == rptr);
   assign full     = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
   // An outstanding read already owns a slot, so leave room for it.
   assign fetch_room = !full && !(pending && (count == PW'(FQ_DEPTH - 1)));

   assign stall     = (memread_enable && !first_cycle) || (stall_cnt != '0);
   assign redirect  = br_late_enable || br_early_enable;
   assign br_target = br_late_enable ? br_late_target : br_early_target;

   assign im_req   = rst_n && !stall && !redirect && fetch_room;
   assign im_addr  = rst_n ? pc_f : RESET_PC;
   // Stale-epoch responses belong to a squashed stream and are dropped.
   assign push     = im_valid && pending && (pend_epoch == epoch) && !redirect;
   assign out_valid = rst_n && !empty && !stall && !redirect;
   assign pop      = out_valid && out_ready;
   assign pc_out   = out_valid ? q_pc[rptr[AW-1:0]] : '0;
   assign inst_out = out_valid ? q_inst[rptr[AW-1:0]] : '0;
   assign br_late_done_d1 = rst_n && late_d1;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pc_f        <= RESET_PC;
         pend_pc     <= RESET_PC;
         wptr        <= '0;
         rptr        <= '0;
         pending     <= 1'b0;
         pend_epoch  <= 1'b0;
         epoch       <= 1'b0;
         stall_cnt   <= '0;
         first_cycle <= 1'b1;
         late_d1     <= 1'b0;
      end else begin
         first_cycle <= 1'b0;
         late_d1     <= br_late_enable;
         if (memread_enable)
            stall_cnt <= SW'(MEMREAD_STALL - 1);
         else if (stall_cnt != '0)
            stall_cnt <= stall_cnt - 1'b1;

         if (im_req) begin
            pending    <= 1'b1;
            pend_epoch <= epoch;
            pend_pc    <= pc_f;
            pc_f       <= pc_f + XLEN'(4);
         end else if (im_valid) begin
            pending    <= 1'b0;
         end

         if (push)
            wptr <= wptr + 1'b1;

         if (redirect) begin
            pc_f  <= br_target;
            epoch <= ~epoch;
            rptr  <= wptr;
         end else if (pop) begin
            rptr  <= rptr + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst_n && push) begin
         q_pc[wptr[AW-1:0]]   <= pend_pc;
         q_inst[wptr[AW-1:0]] <= im_rdata;
      end
   end

endmodule

// File: tb/tb_pipeline_fetch_q.sv
// Randomized scoreboard bench for pipeline_fetch_q: the bench plays instruction
// memory and predicts the fetch address stream and the delivered instruction stream.
module tb_pipeline_fetch_q;

   localparam int XLEN = 32;
   localparam int FQ_DEPTH = 4;
   localparam int MS = 3;
   localparam logic [31:0] RPC = 32'h0;
   localparam int NCYC = 1600;

   logic            clk, rst_n;
   logic            im_req, im_valid, out_valid, out_ready, br_late_done_d1;
   logic [XLEN-1:0] im_addr, pc_out, br_late_target, br_early_target;
   logic [31:0]     im_rdata, inst_out;
   logic            br_late_enable, br_early_enable, memread_enable;

   pipeline_fetch_q #(.XLEN(XLEN), .FQ_DEPTH(FQ_DEPTH), .MEMREAD_STALL(MS), .RESET_PC(RPC)) dut (
      .clk(clk), .rst_n(rst_n), .im_req(im_req), .im_addr(im_addr), .im_rdata(im_rdata),
      .im_valid(im_valid), .br_late_enable(br_late_enable), .br_late_target(br_late_target),
      .br_early_enable(br_early_enable), .br_early_target(br_early_target),
      .memread_enable(memread_enable), .out_valid(out_valid), .out_ready(out_ready),
      .pc_out(pc_out), .inst_out(inst_out), .br_late_done_d1(br_late_done_d1));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct { logic [31:0] pc; logic [31:0] inst; } ent_t;
   ent_t exp_q[$];
   int   vecs = 0, errs = 0;
   bit   m_redirect, m_stall, popped;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exv);
      vecs++;
      if (act !== exv) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exv);
      end
   endtask

   // Driver + fetch-side model: expected address stream and slot accounting.
   initial begin
      logic [31:0] m_pc, plan_pc, plan_data, cur_pc, cur_data;
      bit          plan_v, cur_v, first, prev_late, exp_req;
      int          stall_end;
      m_pc = RPC; plan_v = 0; first = 1; prev_late = 0; stall_end = -1;
      plan_pc = '0; plan_data = '0;
      rst_n = 0; im_valid = 0; im_rdata = '0; out_ready = 0;
      br_late_enable = 0; br_early_enable = 0; memread_enable = 0;
      br_late_target = '0; br_early_target = '0;
      for (int cyc = 0; cyc < NCYC; cyc++) begin
         @(posedge clk); #1;
         rst_n = !(cyc < 2 || cyc == 110 || (cyc >= 120 && $urandom_range(199) == 0));
         if ((cyc >= 31 && cyc <= 50) || (cyc >= 80 && cyc <= 91)) out_ready = 0;
         else if (cyc >= 120) out_ready = ($urandom_range(3) != 0);
         else out_ready = 1;
         br_late_enable  = (cyc == 70) || (cyc >= 120 && $urandom_range(99) < 3);
         br_early_enable = (cyc == 70) || (cyc == 92) || (cyc >= 120 && $urandom_range(99) < 3);
         br_late_target  = ($urandom_range(7) == 0) ? 32'hFFFF_FFF4 : ($urandom & ~32'h3);
         br_early_target = $urandom & ~32'h3;
         if (cyc == 70) begin br_late_target = 32'h100; br_early_target = 32'h200; end
         if (cyc == 92) br_early_target = 32'h40;
         memread_enable = (cyc == 60) || (cyc >= 120 && $urandom_range(99) < 4);
         cur_v = plan_v; cur_pc = plan_pc; cur_data = plan_data;
         im_valid = plan_v;
         im_rdata = plan_v ? plan_data : $urandom;
         if (cyc == 111) im_valid = 1;  // unsolicited response right after reset
         m_redirect = rst_n && (br_late_enable || br_early_enable);
         m_stall = rst_n && ((memread_enable && !first) || cyc <= stall_end);
         popped = 0;
         @(negedge clk); #1;
         if (!rst_n) begin
            chk("rst_im_req", im_req, 0);
            chk("rst_im_addr", im_addr, RPC);
            chk("rst_br_done", br_late_done_d1, 0);
            exp_q.delete();
            m_pc = RPC; plan_v = 0; first = 1; prev_late = 0; stall_end = -1;
         end else begin
            chk("br_late_done_d1", br_late_done_d1, prev_late);
            exp_req = !m_redirect && !m_stall &&
                      (exp_q.size() + int'(popped) + int'(cur_v) < FQ_DEPTH);
            chk("im_req", im_req, exp_req);
            if (im_req && exp_req) chk("im_addr", im_addr, m_pc);
            if (cur_v && !m_redirect) exp_q.push_back('{pc: cur_pc, inst: cur_data});
            plan_v = im_req;
            plan_pc = m_pc;
            plan_data = $urandom;
            if (exp_req) m_pc = m_pc + 32'd4;
            if (m_redirect) begin
               exp_q.delete();
               m_pc = br_late_enable ? br_late_target : br_early_target;
            end
            if (memread_enable) stall_end = cyc + MS - 1;
            prev_late = br_late_enable;
            first = 0;
         end
      end
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

   // Monitor: compares whatever DUT offers against the scoreboard head.
   initial begin
      bit deliverable;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            chk("rst_out_valid", out_valid, 0);
            chk("rst_inst_out", inst_out, 0);
            chk("rst_pc_out", pc_out, 0);
         end else begin
            deliverable = !m_redirect && !m_stall && (exp_q.size() > 0);
            chk("out_valid", out_valid, deliverable);
            if (out_valid && deliverable) begin
               chk("pc_out", pc_out, exp_q[0].pc);
               chk("inst_out", inst_out, exp_q[0].inst);
               if (out_ready) begin
                  void'(exp_q.pop_front());
                  popped = 1;
               end
            end else if (!out_valid) begin
               chk("inst_out_idle", inst_out, 0);
            end
         end
      end
   end

endmodule
